// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and default widths for the writeback stage
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int PC_W_DEF   = 32;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_DONE  = 2'd1,
    ST_WAIT  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_ld_if.sv
// rtl/wb_stage_ld_if.sv - MEM-to-WB instruction bus with its allowin back-pressure
interface wb_stage_ld_if
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int PC_W   = PC_W_DEF
);
  localparam int STB_W = DATA_W / 8;
  localparam int OFF_W = $clog2(STB_W);

  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic [STB_W-1:0]  ms_wstrb;
  logic [REG_AW-1:0] ms_dest;
  logic [DATA_W-1:0] ms_result;
  logic              ms_late;
  logic [OFF_W-1:0]  ms_ld_off;
  logic [1:0]        ms_ld_size;
  logic              ms_ld_sext;
  logic [PC_W-1:0]   ms_pc;

  modport master (
    input  ws_allowin,
    output ms_to_ws_valid, ms_wstrb, ms_dest, ms_result, ms_late,
           ms_ld_off, ms_ld_size, ms_ld_sext, ms_pc
  );

  modport slave (
    output ws_allowin,
    input  ms_to_ws_valid, ms_wstrb, ms_dest, ms_result, ms_late,
           ms_ld_off, ms_ld_size, ms_ld_sext, ms_pc
  );

endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - shifts raw load data down by the byte offset and extends it
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_sext,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;

  assign w_shifted = i_data >> {i_off, 3'b000};

  // Size 3 has no encoding of its own and falls through to the full-word path.
  always_comb begin
    o_data = w_shifted;
    case (i_size)
      LD_B:    o_data = {{(DATA_W-8){i_sext & w_shifted[7]}}, w_shifted[7:0]};
      LD_H:    o_data = {{(DATA_W-16){i_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage_ld.sv
// rtl/wb_stage_ld.sv - writeback stage that holds loads until their response arrives
// Optional stall counter output ws_stall_cnt is built when WB_STALL_CNT_EN is defined.
module wb_stage_ld
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef WB_STALL_CNT_EN
  output logic [31:0]           ws_stall_cnt,
`endif
  wb_stage_ld_if.slave          ms,
  input  logic                  resp_valid,
  input  logic [DATA_W-1:0]     resp_data,
  output logic [DATA_W/8-1:0]   ws_rf_we,
  output logic [REG_AW-1:0]     ws_rf_waddr,
  output logic [DATA_W-1:0]     ws_rf_wdata,
  output logic                  ws_fwd_valid,
  output logic                  ws_fwd_ready,
  output logic [REG_AW-1:0]     ws_fwd_dest,
  output logic [DATA_W-1:0]     ws_fwd_data,
  output logic [PC_W-1:0]       debug_wb_pc,
  output logic [DATA_W/8-1:0]   debug_wb_rf_wen,
  output logic [REG_AW-1:0]     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]     debug_wb_rf_wdata
);

  localparam int STB_W = DATA_W / 8;
  localparam int OFF_W = $clog2(STB_W);

  wb_state_e         r_state;
  logic [STB_W-1:0]  r_wstrb;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_result;
  logic              r_late;
  logic [OFF_W-1:0]  r_ld_off;
  logic [1:0]        r_ld_size;
  logic              r_ld_sext;
  logic [PC_W-1:0]   r_pc;

  logic              w_ready_go;
  logic              w_capture;
  logic              w_dest_nz;
  logic [DATA_W-1:0] w_ld_data;
  logic [DATA_W-1:0] w_wdata;

  assign w_ready_go    = (r_state == ST_DONE) | ((r_state == ST_WAIT) & resp_valid);
  assign ms.ws_allowin = (r_state == ST_EMPTY) | w_ready_go;
  assign w_capture     = ms.ms_to_ws_valid & ms.ws_allowin;
  assign w_dest_nz     = (r_dest != '0);

  // A retiring instruction and a newly captured one may share a cycle; capture wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_wstrb   <= '0;
      r_dest    <= '0;
      r_result  <= '0;
      r_late    <= 1'b0;
      r_ld_off  <= '0;
      r_ld_size <= '0;
      r_ld_sext <= 1'b0;
      r_pc      <= '0;
    end else if (w_capture) begin
      r_state   <= ms.ms_late ? ST_WAIT : ST_DONE;
      r_wstrb   <= ms.ms_wstrb;
      r_dest    <= ms.ms_dest;
      r_result  <= ms.ms_result;
      r_late    <= ms.ms_late;
      r_ld_off  <= ms.ms_ld_off;
      r_ld_size <= ms.ms_ld_size;
      r_ld_sext <= ms.ms_ld_sext;
      r_pc      <= ms.ms_pc;
    end else if (w_ready_go) begin
      r_state   <= ST_EMPTY;
    end
  end

  wb_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .i_data (resp_data),
    .i_off  (r_ld_off),
    .i_size (r_ld_size),
    .i_sext (r_ld_sext),
    .o_data (w_ld_data)
  );

  assign w_wdata = r_late ? w_ld_data : r_result;

  assign ws_rf_we     = r_wstrb & {STB_W{w_ready_go & w_dest_nz}};
  assign ws_rf_waddr  = r_dest;
  assign ws_rf_wdata  = w_wdata;

  assign ws_fwd_valid = (r_state != ST_EMPTY) & (|r_wstrb) & w_dest_nz;
  assign ws_fwd_ready = w_ready_go;
  assign ws_fwd_dest  = ws_fwd_valid ? r_dest : '0;
  assign ws_fwd_data  = w_wdata;

  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_wen   = ws_rf_we;
  assign debug_wb_rf_wnum  = r_dest;
  assign debug_wb_rf_wdata = w_wdata;

`ifdef WB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_stall_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !resp_valid && (ws_stall_cnt != 32'hFFFF_FFFF)) begin
      ws_stall_cnt <= ws_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/wb_stage_ld.md
Name: wb_stage_ld

Overview:
- Parametrised successor to the single-cycle writeback stage of the 5-stage in-order CPU pipeline.
- Adds late-result loads: the stage holds an instruction until its data response arrives, then aligns and sign/zero-extends the loaded data.
- Adds byte-strobe register writes, r0 write suppression, and a forwarding bus that carries a result-ready flag.
- Sits between the MEM stage and the register file and debug trace port.

Parameters:
- DATA_W, 32, datapath width; must be a multiple of 8, at least 32.
- REG_AW, 5, register-file address width.
- PC_W, 32, PC width.
- STB_W, DATA_W/8, byte-strobe width (derived, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ws_allowin  out  1  WB can accept a new instruction this cycle.
- ms_to_ws_valid  in  1  MEM presents a valid instruction.
- ms_wstrb  in  STB_W  byte write strobes; all-zero means no register write.
- ms_dest  in  REG_AW  destination register.
- ms_result  in  DATA_W  final result for non-late instructions.
- ms_late  in  1  result comes from the response channel (load).
- ms_ld_off  in  $clog2(STB_W)  byte offset of the load within the word.
- ms_ld_size  in  2  0=byte, 1=half, 2=word.
- ms_ld_sext  in  1  sign-extend the loaded value.
- ms_pc  in  PC_W  instruction PC.
- resp_valid  in  1  load data valid, single-cycle pulse.
- resp_data  in  DATA_W  raw load data.
- ws_rf_we  out  STB_W  register-file byte write enables.
- ws_rf_waddr  out  REG_AW  register-file write address.
- ws_rf_wdata  out  DATA_W  register-file write data.
- ws_fwd_valid  out  1  WB holds a valid instruction with nonzero strobe and dest≠0.
- ws_fwd_ready  out  1  forwarded data is usable this cycle.
- ws_fwd_dest  out  REG_AW  forwarding destination.
- ws_fwd_data  out  DATA_W  forwarding data.
- debug_wb_pc  out  PC_W  trace PC.
- debug_wb_rf_wen  out  STB_W  trace write enables.
- debug_wb_rf_wnum  out  REG_AW  trace register number.
- debug_wb_rf_wdata  out  DATA_W  trace write data.

Behaviour:
- Reset state: ws_valid=0, state=EMPTY, all input registers 0.
  - Consequently all outputs are 0 and ws_allowin=1.
- States:
  - EMPTY: no instruction held.
  - DONE: holding a non-late instruction.
  - WAIT: holding a late instruction whose response has not arrived.
- ready_go = (state==DONE) | (state==WAIT & resp_valid).
- ws_allowin = (state==EMPTY) | ready_go.
- Capture: on ms_to_ws_valid & ws_allowin, register all ms_* fields. Next state is WAIT if ms_late, else DONE.
- Drain: on ready_go with no capture, next state is EMPTY.
- Simultaneous drain and capture (back-to-back) takes the capture transition. Zero bubble: one instruction retires per cycle when nothing is late.
- Load formatting:
  - shifted = resp_data >> (8*ld_off).
  - The low 8, 16 or DATA_W bits of shifted are extended per ld_sext to DATA_W.
  - Misaligned size/offset combinations are not checked; result = formatted bits of the shifted value.
  - Size 3 behaves as word.
- wdata = late ? formatted(resp_data) : result.
- ws_rf_we = wstrb & {STB_W{ready_go & dest≠0}}. Writes happen only in the retiring cycle.
  - Writes to r0 are suppressed; the trace wen is suppressed too.
- ws_rf_waddr = dest; ws_rf_wdata = wdata.
- Latency:
  - Non-late: 1 cycle after capture, same as the previous stage.
  - Late: retires in the cycle resp_valid is seen in WAIT, i.e. unbounded.
- Response handling: resp_valid outside WAIT is ignored; no state change and no write.
- Forwarding:
  - ws_fwd_dest = dest when ws_fwd_valid, else 0.
  - ws_fwd_ready = (state==DONE) | (state==WAIT & resp_valid).
  - ws_fwd_data = wdata.
  - ID must stall on a dest match while ws_fwd_ready=0.
- Trace: debug_wb_* mirror ws_rf_* and the held pc.
- Reset mid-WAIT: the instruction is dropped, state goes to EMPTY, no write. A response arriving after reset is ignored.

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- Defined:
  - Adds output ws_stall_cnt, 32 bits, cleared by reset.
  - Increments by 1 every cycle in WAIT with resp_valid=0.
  - Saturates at 0xFFFF_FFFF.
- Undefined: no port, no counter logic; all other behaviour identical.

Decomposition:
- Shared package wb_pkg holds:
  - ld_size encodings (LD_B=0, LD_H=1, LD_W=2).
  - State encodings EMPTY/DONE/WAIT.
  - Default DATA_W, REG_AW, PC_W.
- One combinational sub-module, wb_load_align: inputs raw data, off, size, sext; output extended data. Parametrised by DATA_W; unit-tested separately.

Test Plan:
- Non-late stream: three back-to-back instructions (dest 3/4/5, wstrb 0xF, results 0x11/0x22/0x33).
  - Required: one RF write per cycle, each 1 cycle after capture.
  - Required: ws_allowin=1 throughout.
- Load lb: ld_off=2, sext=1, resp arrives 4 cycles after capture with resp_data=0x12_80_56_78.
  - Required: ws_allowin=0 for 3 cycles.
  - Required: write 0xFFFF_FF80 in the resp_valid cycle.
  - Required: ws_fwd_ready=0 until then.
- Load lhu: ld_off=2, resp_data=0x8001_0000 -> writes 0x0000_8001.
- Load with resp_valid in the same cycle as a new ms_to_ws_valid -> retire and capture in one cycle; the next instruction writes the following cycle.
- dest=0 with wstrb=0xF -> ws_rf_we=0, debug_wb_rf_wen=0, ws_fwd_valid=0.
- Reset asserted while in WAIT, then resp_valid pulsed -> no write, state EMPTY. With WB_STALL_CNT_EN, ws_stall_cnt=0 after reset.
